// File: rtl/prbs_pkg.sv
// Shared definitions for the 7-bit PRBS link: word width, checker states and
// the x^7+x^6+1 successor function used to predict the next received word.
package prbs_pkg;

    localparam int PRBS7_WIDTH = 7;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    function automatic logic [PRBS7_WIDTH-1:0] prbs7Next(input logic [PRBS7_WIDTH-1:0] v);
        return {v[5:0], v[6] ^ v[5]};
    endfunction

endpackage

// File: rtl/hexToSevenSeg.sv
// Nibble to seven-segment decoder, active-low segments, bit order {g,f,e,d,c,b,a}.
module hexToSevenSeg (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    logic [6:0] lit;

    always_comb begin
        lit = 7'h00;
        case (i_nibble)
            4'h0: lit = 7'h3F;
            4'h1: lit = 7'h06;
            4'h2: lit = 7'h5B;
            4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66;
            4'h5: lit = 7'h6D;
            4'h6: lit = 7'h7D;
            4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F;
            4'h9: lit = 7'h6F;
            4'hA: lit = 7'h77;
            4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39;
            4'hD: lit = 7'h5E;
            4'hE: lit = 7'h79;
            4'hF: lit = 7'h71;
            default: lit = 7'h00;
        endcase
    end

    assign o_seg = ~lit;

endmodule

// File: rtl/prbs7_checker.sv
// PRBS7 receive checker: self-synchronises to the incoming state words, flags
// lock, counts mispredicted words while locked and drives two hex displays.
module prbs7_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3
) (
    input  logic                   i_clk,
    input  logic                   i_srst,
    input  logic                   i_valid,
    input  logic [PRBS7_WIDTH-1:0] i_value,
    input  logic                   i_clearErrors,
    output logic                   o_locked,
    output logic [7:0]             o_errorCount,
    output logic [6:0]             o_SEG0,
    output logic [6:0]             o_SEG1
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(LOSS_COUNT + 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_COUNT - 1);
    localparam logic [7:0]         ERR_MAX    = 8'hFF;

    state_e                   state_q, state_d;
    logic [PRBS7_WIDTH-1:0]   ref_q, ref_d;
    logic [MATCH_W-1:0]       match_q, match_d;
    logic [MISS_W-1:0]        miss_q, miss_d;
    logic [7:0]               err_q, err_d;
    logic                     locked_q, locked_d;

    logic [PRBS7_WIDTH-1:0]   predicted;
    logic                     hit;
    logic                     is_zero;
    logic                     err_inc;

    assign predicted = prbs7Next(ref_q);
    assign hit       = (i_value == predicted);
    assign is_zero   = (i_value == '0);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_inc = 1'b0;

        if (i_valid) begin
            unique case (state_q)
                SEARCH: begin
                    if (!is_zero) begin
                        ref_d   = i_value;
                        match_d = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (hit) begin
                        ref_d   = i_value;
                        match_d = match_q + 1'b1;
                        if (match_q == MATCH_LAST) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else if (!is_zero) begin
                        ref_d   = i_value;
                        match_d = '0;
                    end else begin
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        ref_d  = i_value;
                        miss_d = '0;
                    end else begin
                        // Flywheel: keep predicting from our own sequence,
                        // never adopt a corrupt word.
                        ref_d   = predicted;
                        err_inc = 1'b1;
                        if (miss_q == MISS_LAST) begin
                            state_d = SEARCH;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        err_d = err_q;
        if (i_clearErrors) begin
            err_d = '0;
        end else if (err_inc && (err_q != ERR_MAX)) begin
            err_d = err_q + 8'd1;
        end

        locked_d = (state_d == LOCKED);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q  <= SEARCH;
            ref_q    <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            err_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign o_locked     = locked_q;
    assign o_errorCount = err_q;

    hexToSevenSeg u_seg0 (
        .i_nibble (err_q[3:0]),
        .o_seg    (o_SEG0)
    );

    hexToSevenSeg u_seg1 (
        .i_nibble (err_q[7:4]),
        .o_seg    (o_SEG1)
    );

endmodule

// File: tb/tb_prbs7_checker.sv
// Randomised self-checking bench for prbs7_checker against a behavioural
// model of acquisition, lock, flywheel and the saturating error counter.
module tb_prbs7_checker;

    localparam int LOCK_COUNT = 4;
    localparam int LOSS_COUNT = 3;
    localparam int GAP_WORDS  = 20;

    logic       i_clk;
    logic       i_srst;
    logic       i_valid;
    logic [6:0] i_value;
    logic       i_clearErrors;
    logic       o_locked;
    logic [7:0] o_errorCount;
    logic [6:0] o_SEG0;
    logic [6:0] o_SEG1;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: whether a reference word has been acquired, the run of
    // correct predictions since acquisition, lock flag, misses while locked.
    bit         m_acq;
    bit         m_locked;
    int         m_run;
    int         m_misses;
    logic [6:0] m_ref;
    int         m_err;
    logic [6:0] gen;

    prbs7_checker #(
        .LOCK_COUNT (LOCK_COUNT),
        .LOSS_COUNT (LOSS_COUNT)
    ) dut (
        .i_clk         (i_clk),
        .i_srst        (i_srst),
        .i_valid       (i_valid),
        .i_value       (i_value),
        .i_clearErrors (i_clearErrors),
        .o_locked      (o_locked),
        .o_errorCount  (o_errorCount),
        .o_SEG0        (o_SEG0),
        .o_SEG1        (o_SEG1)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Successor of a PRBS7 state word: shift left, feed back tap6 xor tap5.
    function automatic logic [6:0] seq_next(input logic [6:0] v);
        int x;
        x = int'(v);
        return 7'(((x * 2) % 128) + (((x >> 6) ^ (x >> 5)) & 1));
    endfunction

    // Expected active-low pattern built from the list of lit segments.
    function automatic logic [6:0] seg_ref(input int d);
        string lit;
        logic [6:0] r;
        int idx;
        r = 7'h7F;
        case (d)
            0: lit = "abcdef";   1: lit = "bc";      2: lit = "abdeg";   3: lit = "abcdg";
            4: lit = "bcfg";     5: lit = "acdfg";   6: lit = "acdefg";  7: lit = "abc";
            8: lit = "abcdefg";  9: lit = "abcdfg";  10: lit = "abcefg"; 11: lit = "cdefg";
            12: lit = "adef";    13: lit = "bcdeg";  14: lit = "adefg";  default: lit = "aefg";
        endcase
        for (int i = 0; i < lit.len(); i++) begin
            idx = int'(lit[i]) - 97;
            r[idx[2:0]] = 1'b0;
        end
        return r;
    endfunction

    task automatic model_step(input logic srst, input logic valid,
                              input logic [6:0] value, input logic clr);
        logic [6:0] pred;
        bit bump;
        bump = 1'b0;
        if (srst) begin
            m_acq = 0; m_locked = 0; m_run = 0; m_misses = 0; m_ref = '0; m_err = 0;
            return;
        end
        if (valid) begin
            pred = seq_next(m_ref);
            if (m_locked) begin
                if (value == pred) begin
                    m_ref = value;
                    m_misses = 0;
                end else begin
                    m_ref = pred;
                    bump = 1'b1;
                    m_misses++;
                    if (m_misses == LOSS_COUNT) begin
                        m_locked = 0; m_acq = 0; m_misses = 0;
                    end
                end
            end else if (m_acq) begin
                if (value == pred) begin
                    m_ref = value;
                    m_run++;
                    if (m_run == LOCK_COUNT) begin
                        m_locked = 1; m_misses = 0;
                    end
                end else if (value != 7'h00) begin
                    m_ref = value; m_run = 0;
                end else begin
                    m_acq = 0;
                end
            end else if (value != 7'h00) begin
                m_acq = 1; m_ref = value; m_run = 0;
            end
        end
        if (clr) m_err = 0;
        else if (bump && m_err < 255) m_err++;
    endtask

    // One clock: drive on the falling edge, update the model at the rising
    // edge, leave the caller 1 time unit after the edge to sample outputs.
    task automatic step(input logic srst, input logic valid,
                        input logic [6:0] value, input logic clr);
        @(negedge i_clk);
        i_srst = srst; i_valid = valid; i_value = value; i_clearErrors = clr;
        @(posedge i_clk);
        model_step(srst, valid, value, clr);
        #1;
    endtask

    task automatic send_clean();
        gen = seq_next(gen);
        step(1'b0, 1'b1, gen, 1'b0);
    endtask

    task automatic send_corrupt(input logic clr);
        logic [6:0] mask;
        mask = 7'($urandom_range(1, 127));
        gen = seq_next(gen);
        step(1'b0, 1'b1, gen ^ mask, clr);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 7'h55, 1'b0);
        step(1'b1, 1'b0, 7'h00, 1'b0);
        n_checks++;
        if (o_locked !== 1'b0 || o_errorCount !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_state: locked=%0b count=%0h, want locked=0 count=00", o_locked, o_errorCount);
        end
        n_checks++;
        if (o_SEG0 !== seg_ref(0) || o_SEG1 !== seg_ref(0)) begin
            n_errors++;
            $display("FAIL reset_seg: seg1=%b seg0=%b, want %b %b", o_SEG1, o_SEG0, seg_ref(0), seg_ref(0));
        end
    endtask

    task automatic test_lock_acquire();
        gen = 7'h01;
        step(1'b0, 1'b1, gen, 1'b0);
        for (int k = 2; k <= LOCK_COUNT + 1; k++) begin
            n_checks++;
            if (o_locked !== 1'b0) begin
                n_errors++;
                $display("FAIL acquire_early word %0d: locked=%0b, want 0", k - 1, o_locked);
            end
            send_clean();
        end
        n_checks++;
        if (o_locked !== 1'b1 || o_errorCount !== 8'h00 || o_locked !== m_locked) begin
            n_errors++;
            $display("FAIL acquire_lock: locked=%0b count=%0h, want locked=1 count=00", o_locked, o_errorCount);
        end
        n_checks++;
        if (o_SEG0 !== seg_ref(0) || o_SEG1 !== seg_ref(0)) begin
            n_errors++;
            $display("FAIL acquire_seg: seg1=%b seg0=%b, want %b %b", o_SEG1, o_SEG0, seg_ref(0), seg_ref(0));
        end
    endtask

    task automatic test_single_error();
        gen = seq_next(gen);
        step(1'b0, 1'b1, gen ^ 7'h01, 1'b0);
        n_checks++;
        if (o_locked !== 1'b1 || o_errorCount !== 8'd1) begin
            n_errors++;
            $display("FAIL single_error: locked=%0b count=%0d, want locked=1 count=1", o_locked, o_errorCount);
        end
        send_clean();
        n_checks++;
        if (o_locked !== 1'b1 || o_errorCount !== 8'd1 || o_errorCount !== 8'(m_err)) begin
            n_errors++;
            $display("FAIL flywheel: locked=%0b count=%0d, want locked=1 count=1", o_locked, o_errorCount);
        end
    endtask

    task automatic test_loss_relock();
        step(1'b0, 1'b0, 7'h00, 1'b1);
        n_checks++;
        if (o_locked !== 1'b1 || o_errorCount !== 8'd0) begin
            n_errors++;
            $display("FAIL clear_idle: locked=%0b count=%0d, want locked=1 count=0", o_locked, o_errorCount);
        end
        for (int k = 1; k <= LOSS_COUNT; k++) begin
            send_corrupt(1'b0);
            n_checks++;
            if (o_locked !== (k < LOSS_COUNT) || o_errorCount !== 8'(k)) begin
                n_errors++;
                $display("FAIL loss corrupt %0d: locked=%0b count=%0d, want locked=%0b count=%0d",
                         k, o_locked, o_errorCount, (k < LOSS_COUNT), k);
            end
        end
        for (int k = 1; k <= LOCK_COUNT + 1; k++) begin
            send_clean();
            n_checks++;
            if (o_locked !== (k == LOCK_COUNT + 1) || o_errorCount !== 8'(LOSS_COUNT)) begin
                n_errors++;
                $display("FAIL relock word %0d: locked=%0b count=%0d, want locked=%0b count=%0d",
                         k, o_locked, o_errorCount, (k == LOCK_COUNT + 1), LOSS_COUNT);
            end
        end
    endtask

    task automatic test_zero_words();
        step(1'b1, 1'b0, 7'h00, 1'b0);
        for (int k = 0; k < 2 * LOCK_COUNT; k++) begin
            step(1'b0, 1'b1, 7'h00, 1'b0);
            n_checks++;
            if (o_locked !== 1'b0 || o_locked !== m_locked) begin
                n_errors++;
                $display("FAIL zero_stream %0d: locked=%0b, want 0", k, o_locked);
            end
        end
        gen = 7'($urandom_range(1, 127));
        step(1'b0, 1'b1, gen, 1'b0);
        step(1'b0, 1'b1, 7'h00, 1'b0);
        for (int k = 1; k <= LOCK_COUNT + 1; k++) begin
            send_clean();
            n_checks++;
            if (o_locked !== (k == LOCK_COUNT + 1) || o_locked !== m_locked) begin
                n_errors++;
                $display("FAIL zero_in_verify word %0d: locked=%0b, want %0b", k, o_locked, (k == LOCK_COUNT + 1));
            end
        end
    endtask

    task automatic test_saturation();
        int want;
        step(1'b1, 1'b0, 7'h00, 1'b0);
        gen = 7'($urandom_range(1, 127));
        step(1'b0, 1'b1, gen, 1'b0);
        for (int k = 0; k < LOCK_COUNT; k++) send_clean();
        for (int i = 0; i < 300; i++) begin
            send_corrupt(1'b0);
            want = (i + 1 > 255) ? 255 : i + 1;
            n_checks++;
            if (o_locked !== 1'b1 || o_errorCount !== 8'(want) || o_errorCount !== 8'(m_err)) begin
                n_errors++;
                $display("FAIL saturate error %0d: locked=%0b count=%0d, want locked=1 count=%0d",
                         i, o_locked, o_errorCount, want);
            end
            n_checks++;
            if (o_SEG0 !== seg_ref(want % 16) || o_SEG1 !== seg_ref(want / 16)) begin
                n_errors++;
                $display("FAIL saturate_seg %0d: seg1=%b seg0=%b, want %b %b",
                         i, o_SEG1, o_SEG0, seg_ref(want / 16), seg_ref(want % 16));
            end
            send_clean();
        end
        n_checks++;
        if (o_errorCount !== 8'hFF || o_SEG0 !== seg_ref(15) || o_SEG1 !== seg_ref(15)) begin
            n_errors++;
            $display("FAIL saturate_hold: count=%0h seg1=%b seg0=%b, want FF %b %b",
                     o_errorCount, o_SEG1, o_SEG0, seg_ref(15), seg_ref(15));
        end
        send_corrupt(1'b1);
        n_checks++;
        if (o_errorCount !== 8'h00 || o_locked !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_wins: count=%0h locked=%0b, want count=00 locked=1", o_errorCount, o_locked);
        end
    endtask

    task automatic test_gaps();
        logic [6:0] words [GAP_WORDS];
        bit         want_locked [GAP_WORDS];
        int         want_err [GAP_WORDS];
        logic [6:0] g;
        g = 7'($urandom_range(1, 127));
        for (int i = 0; i < GAP_WORDS; i++) begin
            if (i > 0) g = seq_next(g);
            words[i] = g;
            if (i >= LOCK_COUNT + 2 && $urandom_range(0, 4) == 0)
                words[i] = g ^ 7'($urandom_range(1, 127));
        end
        for (int pass = 0; pass < 2; pass++) begin
            step(1'b1, 1'b0, 7'h00, 1'b0);
            for (int i = 0; i < GAP_WORDS; i++) begin
                if (pass == 1) begin
                    for (int j = $urandom_range(0, 3); j > 0; j--)
                        step(1'b0, 1'b0, 7'($urandom_range(0, 127)), 1'b0);
                end
                step(1'b0, 1'b1, words[i], 1'b0);
                if (pass == 0) begin
                    want_locked[i] = m_locked;
                    want_err[i] = m_err;
                end
                n_checks++;
                if (o_locked !== want_locked[i] || o_errorCount !== 8'(want_err[i])) begin
                    n_errors++;
                    $display("FAIL gaps pass %0d word %0d: locked=%0b count=%0d, want locked=%0b count=%0d",
                             pass, i, o_locked, o_errorCount, want_locked[i], want_err[i]);
                end
            end
        end
        step(1'b1, 1'b0, 7'h00, 1'b0);
        gen = 7'($urandom_range(1, 127));
        step(1'b0, 1'b1, gen, 1'b0);
        for (int k = 0; k < LOCK_COUNT; k++) send_clean();
        for (int k = 0; k < LOSS_COUNT; k++) send_corrupt(1'b0);
        send_clean();
        send_clean();
        gen = seq_next(gen);
        step(1'b1, 1'b1, gen, 1'b0);
        n_checks++;
        if (o_locked !== 1'b0 || o_errorCount !== 8'h00 || o_SEG0 !== seg_ref(0)) begin
            n_errors++;
            $display("FAIL reset_mid_verify: locked=%0b count=%0h, want locked=0 count=00", o_locked, o_errorCount);
        end
        for (int k = 1; k <= LOCK_COUNT + 1; k++) begin
            send_clean();
            n_checks++;
            if (o_locked !== (k == LOCK_COUNT + 1) || o_locked !== m_locked) begin
                n_errors++;
                $display("FAIL after_reset word %0d: locked=%0b, want %0b", k, o_locked, (k == LOCK_COUNT + 1));
            end
        end
    endtask

    initial begin
        i_srst = 1'b1; i_valid = 1'b0; i_value = 7'h00; i_clearErrors = 1'b0;
        gen = 7'h01;
        m_acq = 0; m_locked = 0; m_run = 0; m_misses = 0; m_ref = '0; m_err = 0;
        test_reset();
        test_lock_acquire();
        test_single_error();
        test_loss_relock();
        test_zero_words();
        test_saturation();
        test_gaps();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
